// File: rtl/panda_rst_pkg.sv
// Shared types and default constants for the panda reset sequencer.
package panda_rst_pkg;

  typedef enum logic [1:0] {
    ST_FILTER  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  localparam int unsigned DEF_N_DOMAINS   = 2;
  localparam int unsigned DEF_LOCK_FILTER = 4;
  localparam int unsigned DEF_HOLD_CYCLES = 16;
  localparam int unsigned DEF_STAGE_GAP   = 8;
  localparam int unsigned DEF_WDT_CYCLES  = 1048576;

  // Largest of three terminal counts, used to size the shared phase counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/panda_sync_2ff.sv
// Two-flop synchroniser with asynchronous active-high reset to 0.
module panda_sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/panda_rst_seq.sv
// Staged reset sequencer: filters PLL lock, holds all domains in reset, then
// releases them one by one STAGE_GAP cycles apart.
// Optional watchdog in RUN is built only when PANDA_RST_SEQ_WDT_EN is defined.
module panda_rst_seq
  import panda_rst_pkg::*;
#(
  parameter int unsigned N_DOMAINS   = DEF_N_DOMAINS,
  parameter int unsigned LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned STAGE_GAP   = DEF_STAGE_GAP,
  parameter int unsigned WDT_CYCLES  = DEF_WDT_CYCLES
) (
  input  logic                 sys_clk_i,
  input  logic                 rst_i,
  input  logic                 locked_i,
  input  logic                 sw_rst_req_i,
  input  logic                 wdt_kick_i,
  output logic [N_DOMAINS-1:0] rst_o,
  output logic                 ready_o,
  output logic                 wdt_fired_o
);

  localparam int unsigned CNT_MAX = max3(LOCK_FILTER, HOLD_CYCLES, STAGE_GAP);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned SW      = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [SW-1:0]         r_stage, w_stage_nxt;
  logic [N_DOMAINS-1:0]  r_rst, w_rst_nxt;
  logic                  w_lock;
  logic                  w_abort;

  panda_sync_2ff u_lock_sync (
    .i_clk (sys_clk_i),
    .i_rst (rst_i),
    .i_d   (locked_i),
    .o_q   (w_lock)
  );

  // One phase counter serves FILTER, HOLD and the RELEASE gaps; it saturates.
  assign w_cnt_inc = (r_cnt == CW'(CNT_MAX)) ? r_cnt : r_cnt + 1'b1;

`ifdef PANDA_RST_SEQ_WDT_EN
  localparam int unsigned WW = $clog2(WDT_CYCLES + 1);
  logic [WW-1:0] r_wdt, w_wdt_nxt, w_wdt_inc;
  logic          r_fired, w_fired_nxt;

  assign w_wdt_inc   = (r_wdt == WW'(WDT_CYCLES)) ? r_wdt : r_wdt + 1'b1;
  assign wdt_fired_o = r_fired;
`else
  logic w_unused_kick;
  assign w_unused_kick = wdt_kick_i | (WDT_CYCLES == 0);
  assign wdt_fired_o   = 1'b0;
`endif

  // Next-state logic; any abort condition collapses to one return to FILTER.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    w_rst_nxt   = r_rst;
    w_abort     = 1'b0;
`ifdef PANDA_RST_SEQ_WDT_EN
    w_wdt_nxt   = '0;
    w_fired_nxt = r_fired;
`endif
    case (r_state)
      ST_FILTER: begin
        if (!w_lock) begin
          w_cnt_nxt = '0;
        end else if (w_cnt_inc == CW'(LOCK_FILTER)) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_HOLD: begin
        if (!w_lock) begin
          w_abort = 1'b1;
        end else if (w_cnt_inc == CW'(HOLD_CYCLES)) begin
          w_state_nxt  = ST_RELEASE;
          w_cnt_nxt    = '0;
          w_stage_nxt  = '0;
          w_rst_nxt[0] = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_RELEASE: begin
        if (!w_lock || sw_rst_req_i) begin
          w_abort = 1'b1;
        end else if (r_stage == SW'(N_DOMAINS - 1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == CW'(STAGE_GAP)) begin
          w_cnt_nxt   = '0;
          w_stage_nxt = r_stage + 1'b1;
          for (int unsigned k = 0; k < N_DOMAINS; k++) begin
            if (SW'(k) == w_stage_nxt) w_rst_nxt[k] = 1'b0;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_RUN: begin
        if (!w_lock || sw_rst_req_i) begin
          w_abort = 1'b1;
        end
`ifdef PANDA_RST_SEQ_WDT_EN
        else if (wdt_kick_i) begin
          w_wdt_nxt = '0;
        end else if (w_wdt_inc == WW'(WDT_CYCLES)) begin
          w_abort     = 1'b1;
          w_fired_nxt = 1'b1;
        end else begin
          w_wdt_nxt = w_wdt_inc;
        end
`endif
      end
      default: w_abort = 1'b1;
    endcase
    if (w_abort) begin
      w_state_nxt = ST_FILTER;
      w_cnt_nxt   = '0;
      w_stage_nxt = '0;
      w_rst_nxt   = '1;
`ifdef PANDA_RST_SEQ_WDT_EN
      w_wdt_nxt   = '0;
`endif
    end
  end

  // Sequencer state and reset outputs; rst_i reasserts every domain at once.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_FILTER;
      r_cnt   <= '0;
      r_stage <= '0;
      r_rst   <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stage <= w_stage_nxt;
      r_rst   <= w_rst_nxt;
    end
  end

`ifdef PANDA_RST_SEQ_WDT_EN
  // Watchdog count and sticky expiry flag; only rst_i clears the flag.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdt   <= '0;
      r_fired <= 1'b0;
    end else begin
      r_wdt   <= w_wdt_nxt;
      r_fired <= w_fired_nxt;
    end
  end
`endif

  assign rst_o   = r_rst;
  assign ready_o = (r_state == ST_RUN);

endmodule
